rgb_pixel_tx: RTL and testbench

//  Transmit end of the 3-lane serial pixel link (pred/pgreen/pblue) that feeds the grey/black converter.

---
 rtl/rgb_pixel_tx.sv | 194 +++++++++++++++++++
 tb/tb_rgb_pixel_tx.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pixel_tx.sv
// Transmit end of the 3-lane LSB-first serial pixel link: handshake input, small FIFO, 8-clk slot serializer.
// Optional TX_STATS_EN adds saturating pix_sent/underruns counters.
module rgb_pixel_tx #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CH_W  = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            tx_en,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [CH_W-1:0] in_red,
    input  logic [CH_W-1:0] in_green,
    input  logic [CH_W-1:0] in_blue,
    output logic            pred,
    output logic            pgreen,
    output logic            pblue,
    output logic            pix_start,
    output logic            tx_active
`ifdef TX_STATS_EN
    ,
    output logic [15:0]     pix_sent,
    output logic [15:0]     underruns
`endif
);

    localparam int unsigned AW    = $clog2(DEPTH);
    localparam int unsigned PTR_W = AW + 1;
    localparam int unsigned CNT_W = $clog2(CH_W);

    typedef struct packed {
        logic [CH_W-1:0] r;
        logic [CH_W-1:0] g;
        logic [CH_W-1:0] b;
    } pixel_t;

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    pixel_t             shreg_q, shreg_d;
    logic [2:0]         lines_q, lines_d;
    logic               pix_start_q, pix_start_d;
    logic               tx_active_q, tx_active_d;
    logic               in_ready_q, in_ready_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    pixel_t             mem_q [DEPTH];

    logic               push;
    logic               pop;
    logic               load;
    logic               empty;
    pixel_t             head;
    pixel_t             src;
    pixel_t             in_pix;

    function automatic pixel_t shr1(input pixel_t p);
        pixel_t s;
        s.r = p.r >> 1;
        s.g = p.g >> 1;
        s.b = p.b >> 1;
        return s;
    endfunction

    assign in_pix = '{r: in_red, g: in_green, b: in_blue};
    assign empty  = (wr_ptr_q == rd_ptr_q);
    assign head   = mem_q[rd_ptr_q[AW-1:0]];
    assign push   = in_valid & in_ready_q;

    // Slot sequencing: a new slot (real or zero fill) only ever starts on a wrap or from IDLE.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shreg_d     = shreg_q;
        lines_d     = 3'b000;
        pix_start_d = 1'b0;
        pop         = 1'b0;
        load        = 1'b0;
        src         = '0;
        case (state_q)
            IDLE: begin
                if (tx_en && !empty) begin
                    state_d   = RUN;
                    load      = 1'b1;
                    pop       = 1'b1;
                    bit_cnt_d = '0;
                end
            end
            RUN: begin
                if (bit_cnt_q == CNT_W'(CH_W - 1)) begin
                    bit_cnt_d = '0;
                    if (!tx_en) begin
                        state_d = IDLE;
                    end else begin
                        load = 1'b1;
                        pop  = !empty;
                    end
                end else begin
                    bit_cnt_d = bit_cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (pop) begin
            src = head;
        end
        if (load) begin
            lines_d     = {src.r[0], src.g[0], src.b[0]};
            shreg_d     = shr1(src);
            pix_start_d = 1'b1;
        end else if (state_d == RUN) begin
            lines_d = {shreg_q.r[0], shreg_q.g[0], shreg_q.b[0]};
            shreg_d = shr1(shreg_q);
        end
    end

    // Ready is computed from next-cycle pointers so it is a plain flop with no comb path from pop.
    always_comb begin
        wr_ptr_d    = wr_ptr_q + PTR_W'(push);
        rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
        in_ready_d  = ((wr_ptr_d - rd_ptr_d) != PTR_W'(DEPTH));
        tx_active_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            shreg_q     <= '0;
            lines_q     <= 3'b000;
            pix_start_q <= 1'b0;
            tx_active_q <= 1'b0;
            in_ready_q  <= 1'b1;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shreg_q     <= shreg_d;
            lines_q     <= lines_d;
            pix_start_q <= pix_start_d;
            tx_active_q <= tx_active_d;
            in_ready_q  <= in_ready_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
        end
    end

    // Storage needs no reset; validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= in_pix;
        end
    end

    assign pred      = lines_q[2];
    assign pgreen    = lines_q[1];
    assign pblue     = lines_q[0];
    assign pix_start = pix_start_q;
    assign tx_active = tx_active_q;
    assign in_ready  = in_ready_q;

`ifdef TX_STATS_EN
    logic [15:0] pix_sent_q, pix_sent_d;
    logic [15:0] underruns_q, underruns_d;

    always_comb begin
        pix_sent_d  = pix_sent_q;
        underruns_d = underruns_q;
        if (pop && (pix_sent_q != 16'hFFFF)) begin
            pix_sent_d = pix_sent_q + 16'd1;
        end
        if (load && !pop && (underruns_q != 16'hFFFF)) begin
            underruns_d = underruns_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pix_sent_q  <= '0;
            underruns_q <= '0;
        end else begin
            pix_sent_q  <= pix_sent_d;
            underruns_q <= underruns_d;
        end
    end

    assign pix_sent  = pix_sent_q;
    assign underruns = underruns_q;
`endif

endmodule

// File: tb/tb_rgb_pixel_tx.sv
// Bench for rgb_pixel_tx: slot-level reference model checked every cycle, plus directed literal scenarios.
module tb_rgb_pixel_tx;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst_n, tx_en, in_valid;
    logic       in_ready;
    logic [7:0] in_red, in_green, in_blue;
    logic       pred, pgreen, pblue, pix_start, tx_active;
`ifdef TX_STATS_EN
    logic [15:0] pix_sent, underruns;
`endif

    always #5 clk = ~clk;

    rgb_pixel_tx #(.DEPTH(DEPTH), .CH_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tx_en     (tx_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_red    (in_red),
        .in_green  (in_green),
        .in_blue   (in_blue),
        .pred      (pred),
        .pgreen    (pgreen),
        .pblue     (pblue),
        .pix_start (pix_start),
        .tx_active (tx_active)
`ifdef TX_STATS_EN
        ,
        .pix_sent  (pix_sent),
        .underruns (underruns)
`endif
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a pixel queue plus "which pixel is on the wire and which bit of it".
    logic [23:0] mq[$];
    bit          m_valid = 0;
    bit          m_act   = 0;
    int          m_pos   = 0;
    logic [23:0] m_cur   = '0;
    bit          m_ready = 1;
    int          m_sent  = 0;
    int          m_under = 0;

    always @(posedge clk) begin
        bit acc;
        if (!rst_n) begin
            mq.delete();
            m_act   = 0;
            m_pos   = 0;
            m_cur   = '0;
            m_ready = 1;
            m_sent  = 0;
            m_under = 0;
            m_valid = 1;
        end else if (m_valid) begin
            acc = in_valid && (mq.size() < DEPTH);
            if (!m_act) begin
                if (tx_en && mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_act = 1;
                    m_pos = 0;
                    m_sent++;
                end
            end else if (m_pos == 7) begin
                m_pos = 0;
                if (!tx_en) begin
                    m_act = 0;
                end else if (mq.size() > 0) begin
                    m_cur = mq.pop_front();
                    m_sent++;
                end else begin
                    m_cur = '0;
                    m_under++;
                end
            end else begin
                m_pos++;
            end
            if (acc) mq.push_back({in_red, in_green, in_blue});
            m_ready = (mq.size() < DEPTH);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            chk("pred",      32'(pred),      32'(m_act ? m_cur[16 + m_pos] : 1'b0));
            chk("pgreen",    32'(pgreen),    32'(m_act ? m_cur[8 + m_pos]  : 1'b0));
            chk("pblue",     32'(pblue),     32'(m_act ? m_cur[m_pos]      : 1'b0));
            chk("pix_start", 32'(pix_start), 32'(m_act && m_pos == 0));
            chk("tx_active", 32'(tx_active), 32'(m_act));
            chk("in_ready",  32'(in_ready),  32'(m_ready));
`ifdef TX_STATS_EN
            chk("pix_sent",  32'(pix_sent),  32'((m_sent  > 65535) ? 65535 : m_sent));
            chk("underruns", 32'(underruns), 32'((m_under > 65535) ? 65535 : m_under));
`endif
        end
    end

    task automatic drive_pix(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        in_red   = r;
        in_green = g;
        in_blue  = b;
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        tx_en    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input string nm);
        int n = 0;
        while (!pix_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(nm, 32'(pix_start), 32'd1);
    endtask

    logic [7:0] rb, gb, bb;
    int         pidx, starts, act_cyc;

    initial begin
        rst_n    = 1'b0;
        tx_en    = 1'b0;
        in_valid = 1'b0;
        drive_pix(8'h00, 8'h00, 8'h00);
        repeat (3) @(negedge clk);
        chk("rst_in_ready",  32'(in_ready),  32'd1);
        chk("rst_tx_active", 32'(tx_active), 32'd0);
        chk("rst_pred",      32'(pred),      32'd0);
        rst_n = 1'b1;

        // Single pixel, LSB-first with one-cycle latency, followed by an underrun fill slot.
        tx_en    = 1'b1;
        in_valid = 1'b1;
        drive_pix(8'hA5, 8'h3C, 8'h0F);
        @(negedge clk);
        in_valid = 1'b0;
        chk("t1_no_start_yet", 32'(pix_start), 32'd0);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rb[i] = pred;
            gb[i] = pgreen;
            bb[i] = pblue;
            chk("t1_pix_start", 32'(pix_start), 32'(i == 0));
        end
        chk("t1_red_bits",   32'(rb), 32'h0000_00A5);
        chk("t1_green_bits", 32'(gb), 32'h0000_003C);
        chk("t1_blue_bits",  32'(bb), 32'h0000_000F);
        @(negedge clk);
        chk("t3_fill_start",  32'(pix_start), 32'd1);
        chk("t3_fill_pred",   32'(pred),      32'd0);
        chk("t3_fill_active", 32'(tx_active), 32'd1);
`ifdef TX_STATS_EN
        chk("t3_underruns", 32'(underruns), 32'd1);
        chk("t3_pix_sent",  32'(pix_sent),  32'd1);
`endif
        tx_en = 1'b0;
        repeat (9) @(negedge clk);
        chk("t3_stopped", 32'(tx_active), 32'd0);

        // Six pixels into a four-deep FIFO: back-pressure, then a contiguous stream.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
        chk("t2_full_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        chk("t2_still_full", 32'(in_ready), 32'd0);
        tx_en   = 1'b1;
        pidx    = 4;
        starts  = 0;
        act_cyc = 0;
        for (int c = 0; c < 60; c++) begin
            bit acc;
            acc = in_valid && in_ready;
            @(negedge clk);
            if (acc) begin
                pidx++;
                if (pidx < 6) drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
                else          in_valid = 1'b0;
            end
            starts  += int'(pix_start);
            act_cyc += int'(tx_active);
        end
        chk("t2_all_pushed", 32'(pidx),    32'd6);
        chk("t2_slot_count", 32'(starts),  32'd8);
        chk("t2_contiguous", 32'(act_cyc), 32'd60);
`ifdef TX_STATS_EN
        chk("t2_pix_sent",  32'(pix_sent),  32'd6);
        chk("t2_underruns", 32'(underruns), 32'd2);
`endif

        // tx_en dropped at bit 3: slot completes, second pixel stays queued.
        do_reset();
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        in_valid = 1'b0;
        tx_en    = 1'b1;
        wait_start("t4_first_start");
        repeat (3) @(negedge clk);
        tx_en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t4_finish_slot", 32'(tx_active), 32'd1);
        end
        @(negedge clk);
        chk("t4_stopped", 32'(tx_active), 32'd0);
        chk("t4_lines_low", 32'({pred, pgreen, pblue}), 32'd0);
        repeat (3) @(negedge clk);
        tx_en = 1'b1;
        wait_start("t4_resume_start");
        repeat (8) @(negedge clk);
        tx_en = 1'b0;
        repeat (10) @(negedge clk);

        // Reset at bit 5 with three pixels still queued.
        do_reset();
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1;
            drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        in_valid = 1'b0;
        tx_en    = 1'b1;
        wait_start("t5_start");
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        chk("t5_lines_low",  32'({pred, pgreen, pblue}), 32'd0);
        chk("t5_pix_start",  32'(pix_start), 32'd0);
        chk("t5_tx_active",  32'(tx_active), 32'd0);
        chk("t5_in_ready",   32'(in_ready),  32'd1);
        rst_n  = 1'b1;
        starts = 0;
        repeat (20) begin
            @(negedge clk);
            starts += int'(pix_start);
        end
        chk("t5_no_stale", 32'(starts), 32'd0);

        // Randomized traffic with occasional tx_en drops and resets.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            tx_en    = (($urandom % 8) != 0);
            in_valid = (($urandom % 3) != 0);
            rst_n    = (($urandom % 500) != 0);
            drive_pix(8'($urandom), 8'($urandom), 8'($urandom));
            @(negedge clk);
        end
        rst_n    = 1'b1;
        in_valid = 1'b0;
        tx_en    = 1'b0;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
